// File: rtl/sr_drv_pkg.sv
// Shared types and encodings for the SR latch command driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int PRI_DROP = 0;
  localparam int PRI_SET  = 1;
  localparam int PRI_RST  = 2;

  localparam logic DIR_SET = 1'b1;
  localparam logic DIR_RST = 1'b0;

endpackage

// File: rtl/sr_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debounce and a
// one-cycle pulse on each debounced rising edge.
module sr_debounce
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns raw set/reset buttons into a safe s/r/en sequence for a gated SR
// latch: data is set up one cycle before en and held one cycle after it.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2,
  parameter int PRIORITY        = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic cmd_err,
  output logic q_model
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic set_rise, rst_rise;
  logic set_lvl_unused, rst_lvl_unused;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk(clk), .rst_n(rst_n), .din(set_btn), .level(set_lvl_unused), .rise(set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk(clk), .rst_n(rst_n), .din(rst_btn), .level(rst_lvl_unused), .rise(rst_rise)
  );

  logic req_vld, req_dir, err_d;

  always_comb begin
    req_vld = set_rise | rst_rise;
    req_dir = set_rise ? DIR_SET : DIR_RST;
    err_d   = 1'b0;
    if (set_rise && rst_rise) begin
      case (PRIORITY)
        PRI_SET: req_dir = DIR_SET;
        PRI_RST: req_dir = DIR_RST;
        default: begin
          req_vld = 1'b0;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          dir_q, dir_d;
  logic          pend_vld_q, pend_vld_d;
  logic          pend_dir_q, pend_dir_d;
  logic          qm_q, qm_d;
  logic          s_q, s_d, r_q, r_d, en_q, en_d, busy_q, busy_d, err_q;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    dir_d      = dir_q;
    qm_d       = qm_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          state_d    = SETUP;
          dir_d      = pend_dir_q;
          pend_vld_d = 1'b0;
        end
      end
      SETUP: begin
        state_d = STROBE;
        pcnt_d  = '0;
      end
      STROBE: begin
        if (pcnt_q == PW'(PULSE_CYCLES - 1)) state_d = HOLD;
        else pcnt_d = pcnt_q + PW'(1);
      end
      HOLD: begin
        state_d = IDLE;
        qm_d    = dir_q;
      end
      default: state_d = IDLE;
    endcase
    // A new request always wins, even over the one being consumed now.
    if (req_vld) begin
      pend_vld_d = 1'b1;
      pend_dir_d = req_dir;
    end
    // Outputs are decoded from the next state so they register with it.
    busy_d = (state_d != IDLE);
    s_d    = busy_d && (dir_d == DIR_SET);
    r_d    = busy_d && (dir_d == DIR_RST);
    en_d   = (state_d == STROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      dir_q      <= DIR_RST;
      qm_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_RST;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      dir_q      <= dir_d;
      qm_q       <= qm_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign cmd_err = err_q;
  assign q_model = qm_q;

endmodule
